register_display_scheduler: RTL

- Time-multiplexes one shared register renderer across all 11 16-bit CPU registers, replacing per-register renderer instances.
- Takes a coherent per-frame snapshot of the register bus, then tracks the raster line by line and presents the renderer with the index, value, centre Y and highlight flag of the register whose horizontal band contains the current line.
- Sits between the CPU register file export and the VGA renderer, in the pixel clock domain.

---
 rtl/register_display_scheduler_pkg.sv | 29 ++
 rtl/register_change_tracker.sv | 58 +++++
 rtl/register_display_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/register_display_scheduler_pkg.sv
// Shared constants, FSM encoding and bus helpers for the register display scheduler.
package register_display_scheduler_pkg;

    localparam int unsigned NUM_REGS     = 11;
    localparam int unsigned REG_WIDTH    = 16;
    localparam int unsigned REGBUS_WIDTH = NUM_REGS * REG_WIDTH;
    localparam int unsigned DELTA_Y      = 40;
    localparam int unsigned HOLD_FRAMES  = 30;
    localparam int unsigned HOLD_W       = 5;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned COORD_W      = 11;
    localparam int unsigned GEOM_W       = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Register 0 lives in the most significant slice of the bus.
    function automatic logic [REG_WIDTH-1:0] get_reg(
        input logic [REGBUS_WIDTH-1:0] bus,
        input int                      idx
    );
        return bus[REGBUS_WIDTH - 1 - idx * REG_WIDTH -: REG_WIDTH];
    endfunction

endpackage

// File: rtl/register_change_tracker.sv
// Per-frame register snapshot with change detection and highlight hold counters.
// Ports:
//   clk, rst        pixel clock, synchronous active-low reset
//   frame_start     captures the bus into the snapshot (previous snapshot kept)
//   registers       live register bus
//   rd_index        register to read out of the snapshot
//   rd_value        snapshot value of rd_index (combinational read)
//   rd_changed      rd_index is still within its highlight window (combinational read)
module register_change_tracker
    import register_display_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [REGBUS_WIDTH-1:0] registers,
    input  logic [IDX_W-1:0]        rd_index,
    output logic [REG_WIDTH-1:0]    rd_value,
    output logic                    rd_changed
);

    logic [REG_WIDTH-1:0] snap [NUM_REGS];
    logic [REG_WIDTH-1:0] prev [NUM_REGS];
    logic [HOLD_W-1:0]    hold [NUM_REGS];
    logic                 cmp_pending;

    // Snapshot on frame_start; compare the two snapshots one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmp_pending <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                snap[i] <= '0;
                prev[i] <= '0;
                hold[i] <= '0;
            end
        end else begin
            cmp_pending <= frame_start;
            if (frame_start) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    prev[i] <= snap[i];
                    snap[i] <= get_reg(registers, i);
                end
            end
            if (cmp_pending) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (snap[i] != prev[i]) begin
                        hold[i] <= HOLD_W'(HOLD_FRAMES);
                    end else if (hold[i] != '0) begin
                        hold[i] <= hold[i] - HOLD_W'(1);
                    end
                end
            end
        end
    end

    assign rd_value   = snap[rd_index];
    assign rd_changed = (hold[rd_index] != '0);

endmodule

// File: rtl/register_display_scheduler.sv
// Shares one register renderer across all CPU registers by tracking the raster
// and selecting the register whose horizontal band holds the current line.
// Ports:
//   clk, rst                 pixel clock, synchronous active-low reset
//   frame_start, line_start  raster timing pulses (frame_start has priority)
//   y                        current raster line, valid with line_start
//   cx, cy                   centre of the register column
//   registers                live register bus
//   sel_*                    registered selection presented to the renderer
module register_display_scheduler
    import register_display_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic [COORD_W-1:0]      y,
    input  logic [COORD_W-1:0]      cx,
    input  logic [COORD_W-1:0]      cy,
    input  logic [REGBUS_WIDTH-1:0] registers,
    output logic [IDX_W-1:0]        sel_index,
    output logic [REG_WIDTH-1:0]    sel_value,
    output logic [COORD_W-1:0]      sel_cx,
    output logic [COORD_W-1:0]      sel_cy,
    output logic                    sel_valid,
    output logic                    sel_changed
);

    localparam logic signed [GEOM_W-1:0] HALF_SPAN = GEOM_W'(NUM_REGS * DELTA_Y / 2);
    localparam logic signed [GEOM_W-1:0] DELTA_S   = GEOM_W'(DELTA_Y);
    localparam logic signed [GEOM_W-1:0] HALF_BAND = GEOM_W'(DELTA_Y / 2);
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_REGS - 1);

    sched_state_t             state, state_nx;
    logic [IDX_W-1:0]         band, band_nx;
    logic signed [GEOM_W-1:0] boundary, boundary_nx;
    logic signed [GEOM_W-1:0] top_s, y_s;

    logic [IDX_W-1:0]         rd_index;
    logic [REG_WIDTH-1:0]     rd_value;
    logic                     rd_changed;

    logic [IDX_W-1:0]         index_nx;
    logic [REG_WIDTH-1:0]     value_nx;
    logic [COORD_W-1:0]       cx_nx, cy_nx;
    logic                     valid_nx, changed_nx;

    assign top_s = $signed({1'b0, cy}) - HALF_SPAN;
    assign y_s   = $signed({1'b0, y});

    register_change_tracker u_tracker (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .registers   (registers),
        .rd_index    (rd_index),
        .rd_value    (rd_value),
        .rd_changed  (rd_changed)
    );

    // State register: FSM, band counter and next band boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            band     <= '0;
            boundary <= '0;
        end else begin
            state    <= state_nx;
            band     <= band_nx;
            boundary <= boundary_nx;
        end
    end

    // Next-state logic; frame_start overrides a coincident line_start.
    always_comb begin
        state_nx    = state;
        band_nx     = band;
        boundary_nx = boundary;
        if (frame_start) begin
            state_nx = ARMED;
        end else if (line_start) begin
            case (state)
                ARMED: begin
                    if (y_s >= top_s) begin
                        state_nx    = SCAN;
                        band_nx     = '0;
                        boundary_nx = top_s + DELTA_S;
                    end
                end
                SCAN: begin
                    // At most one band per line, even if y is far past the boundary.
                    if (y_s >= boundary) begin
                        if (band == LAST_IDX) begin
                            state_nx = DONE;
                        end else begin
                            band_nx     = band + IDX_W'(1);
                            boundary_nx = boundary + DELTA_S;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: next selection, loaded only on raster pulses.
    always_comb begin
        rd_index   = band_nx;
        valid_nx   = sel_valid;
        index_nx   = sel_index;
        value_nx   = sel_value;
        cx_nx      = sel_cx;
        cy_nx      = sel_cy;
        changed_nx = sel_changed;
        if (frame_start || line_start) begin
            if (state_nx == SCAN) begin
                valid_nx   = 1'b1;
                index_nx   = band_nx;
                value_nx   = rd_value;
                cx_nx      = cx;
                // Centre sits half a band above the next boundary.
                cy_nx      = COORD_W'(boundary_nx - HALF_BAND);
                changed_nx = rd_changed;
            end else begin
                valid_nx   = 1'b0;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_valid   <= 1'b0;
            sel_index   <= '0;
            sel_value   <= '0;
            sel_cx      <= '0;
            sel_cy      <= '0;
            sel_changed <= 1'b0;
        end else begin
            sel_valid   <= valid_nx;
            sel_index   <= index_nx;
            sel_value   <= value_nx;
            sel_cx      <= cx_nx;
            sel_cy      <= cy_nx;
            sel_changed <= changed_nx;
        end
    end

endmodule
